// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl: frame-paced march sequencer for the 5x11 invader formation.
// Each step period it snapshots the alive mask, scans it one column per clock,
// then steps the formation origin sideways or drops it a row at a wall.
// Handshake: i_frame and i_restart are single-clock pulses sampled on the rising
// edge of clk; i_run is a level; o_step is a single-clock pulse, all others are levels.
// Optional feature: define MARCH_SPEEDUP_EN to make the step period track the alive count.
module invader_march_ctrl #(
    parameter logic [9:0] START_X     = 10'd48,
    parameter logic [9:0] START_Y     = 10'd64,
    parameter logic [9:0] COL_W       = 10'd16,
    parameter logic [9:0] ROW_H       = 10'd16,
    parameter logic [9:0] STEP_X      = 10'd2,
    parameter logic [9:0] DROP_Y      = 10'd8,
    parameter logic [9:0] LEFT_BOUND  = 10'd8,
    parameter logic [9:0] RIGHT_BOUND = 10'd632,
    parameter logic [9:0] BOTTOM_Y    = 10'd400,
    parameter logic [5:0] BASE_PERIOD = 6'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame,
    input  logic        i_run,
    input  logic        i_restart,
    input  logic [54:0] i_invaders,
    output logic [9:0]  o_inv_x,
    output logic [9:0]  o_inv_y,
    output logic        o_step,
    output logic        o_anim,
    output logic        o_all_dead,
    output logic        o_invaded,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {S_WAIT, S_SCAN, S_MOVE, S_HALT} state_t;

    state_t      r_state;
    logic [9:0]  r_x, r_y;
    logic        r_dir;          // 0 = marching right, 1 = marching left
    logic        r_step, r_anim, r_all_dead, r_invaded;
    logic [5:0]  r_frame_cnt, r_period;
    logic [54:0] r_snap;
    logic [3:0]  r_col, r_lm, r_rm;
    logic [2:0]  r_bm;
    logic [5:0]  r_count;
    logic        r_seen;         // some column already found alive in this scan

    logic [54:0] w_shift;
    logic [4:0]  w_col_bits;
    logic [2:0]  w_col_pop, w_col_bot;
    logic [6:0]  w_cnt_p1;
    logic        w_trigger;
    logic [10:0] w_left, w_right, w_bottom;
    logic        w_drop, w_invade;
    logic [9:0]  w_x_new, w_y_new;
    logic [5:0]  w_next_period;

    // Column currently being scanned: alive bits per row, population, lowest alive row
    always_comb begin
        w_shift    = r_snap >> r_col;
        w_col_bits = {w_shift[44], w_shift[33], w_shift[22], w_shift[11], w_shift[0]};
        w_col_pop  = 3'd0;
        w_col_bot  = 3'd0;
        for (int r = 0; r < 5; r++) begin
            if (w_col_bits[r]) begin
                w_col_pop = w_col_pop + 3'd1;
                w_col_bot = 3'(r);
            end
        end
    end

    // Frame pacing and the wall / invasion arithmetic, all in 11-bit unsigned math
    always_comb begin
        w_cnt_p1  = {1'b0, r_frame_cnt} + 7'd1;
        w_trigger = w_cnt_p1 >= {1'b0, r_period};
        w_left    = {1'b0, r_x} + 11'(r_lm) * 11'(COL_W);
        w_right   = {1'b0, r_x} + (11'(r_rm) + 11'd1) * 11'(COL_W);
        w_drop    = r_dir ? (w_left < 11'(LEFT_BOUND) + 11'(STEP_X))
                          : (w_right + 11'(STEP_X) > 11'(RIGHT_BOUND));
        w_x_new   = w_drop ? r_x : (r_dir ? r_x - STEP_X : r_x + STEP_X);
        w_y_new   = w_drop ? r_y + DROP_Y : r_y;
        w_bottom  = {1'b0, w_y_new} + (11'(r_bm) + 11'd1) * 11'(ROW_H);
        w_invade  = w_bottom >= 11'(BOTTOM_Y);
`ifdef MARCH_SPEEDUP_EN
        w_next_period = (r_count == 6'd0) ? 6'd1 : r_count;
`else
        w_next_period = BASE_PERIOD;
`endif
    end

    // March FSM: frame counting, column scan, move decision and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT; r_x <= START_X; r_y <= START_Y; r_dir <= 1'b0;
            r_step <= 1'b0; r_anim <= 1'b0; r_all_dead <= 1'b0; r_invaded <= 1'b0;
            r_frame_cnt <= 6'd0; r_period <= 6'd55; r_snap <= '0;
            r_col <= 4'd0; r_lm <= 4'd0; r_rm <= 4'd0; r_bm <= 3'd0;
            r_count <= 6'd0; r_seen <= 1'b0;
        end else if (i_restart) begin
            r_state <= S_WAIT; r_x <= START_X; r_y <= START_Y; r_dir <= 1'b0;
            r_step <= 1'b0; r_anim <= 1'b0; r_all_dead <= 1'b0; r_invaded <= 1'b0;
            r_frame_cnt <= 6'd0; r_period <= 6'd55; r_snap <= '0;
            r_col <= 4'd0; r_lm <= 4'd0; r_rm <= 4'd0; r_bm <= 3'd0;
            r_count <= 6'd0; r_seen <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (r_state != S_HALT) begin
                if (!i_run) begin
                    // Freeze: any scan in flight is thrown away, position untouched
                    r_state     <= S_WAIT;
                    r_frame_cnt <= 6'd0;
                end else begin
                    if (r_state != S_WAIT && i_frame) r_frame_cnt <= w_cnt_p1[5:0];
                    case (r_state)
                        S_WAIT: begin
                            if (i_frame) begin
                                if (w_trigger) begin
                                    r_snap      <= i_invaders;
                                    r_frame_cnt <= 6'd0;
                                    r_col       <= 4'd0;
                                    r_count     <= 6'd0;
                                    r_seen      <= 1'b0;
                                    r_lm        <= 4'd0;
                                    r_rm        <= 4'd0;
                                    r_bm        <= 3'd0;
                                    r_state     <= S_SCAN;
                                end else begin
                                    r_frame_cnt <= w_cnt_p1[5:0];
                                end
                            end
                        end
                        S_SCAN: begin
                            r_count <= r_count + {3'b000, w_col_pop};
                            if (|w_col_bits) begin
                                if (!r_seen) r_lm <= r_col;
                                r_seen <= 1'b1;
                                r_rm   <= r_col;
                                if (w_col_bot > r_bm) r_bm <= w_col_bot;
                            end
                            r_col <= r_col + 4'd1;
                            if (r_col == 4'd10) r_state <= S_MOVE;
                        end
                        S_MOVE: begin
                            if (r_count == 6'd0) begin
                                r_all_dead <= 1'b1;
                                r_state    <= S_HALT;
                            end else begin
                                r_x      <= w_x_new;
                                r_y      <= w_y_new;
                                if (w_drop) r_dir <= ~r_dir;
                                r_step   <= 1'b1;
                                r_anim   <= ~r_anim;
                                r_period <= w_next_period;
                                if (w_invade) begin
                                    r_invaded <= 1'b1;
                                    r_state   <= S_HALT;
                                end else begin
                                    r_state <= S_WAIT;
                                end
                            end
                        end
                        default: r_state <= S_WAIT;
                    endcase
                end
            end
        end
    end

    assign o_inv_x     = r_x;
    assign o_inv_y     = r_y;
    assign o_step      = r_step;
    assign o_anim      = r_anim;
    assign o_all_dead  = r_all_dead;
    assign o_invaded   = r_invaded;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Bench for invader_march_ctrl: two instances (default playfield, and a narrow
// playfield with a high invasion line) driven by shared stimulus and checked
// against a transaction-level model of the march rules.
module tb_invader_march_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame = 1'b0;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic [54:0] invaders = '0;
    logic [9:0]  o_x [2];
    logic [9:0]  o_y [2];
    logic        o_step [2];
    logic        o_anim [2];
    logic        o_dead [2];
    logic        o_inv [2];
    logic [1:0]  o_dbg [2];

    int n_checks = 0;
    int n_errors = 0;

    // clock and watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    invader_march_ctrl u_dut0 (
        .clk(clk), .rst(rst), .i_frame(frame), .i_run(run), .i_restart(restart),
        .i_invaders(invaders), .o_inv_x(o_x[0]), .o_inv_y(o_y[0]), .o_step(o_step[0]),
        .o_anim(o_anim[0]), .o_all_dead(o_dead[0]), .o_invaded(o_inv[0]), .o_dbg_state(o_dbg[0])
    );

    invader_march_ctrl #(.RIGHT_BOUND(10'd226), .BOTTOM_Y(10'd160)) u_dut1 (
        .clk(clk), .rst(rst), .i_frame(frame), .i_run(run), .i_restart(restart),
        .i_invaders(invaders), .o_inv_x(o_x[1]), .o_inv_y(o_y[1]), .o_step(o_step[1]),
        .o_anim(o_anim[1]), .o_all_dead(o_dead[1]), .o_invaded(o_inv[1]), .o_dbg_state(o_dbg[1])
    );

    // ---------------- reference model ----------------
    int rb_cfg [2] = '{632, 226};
    int by_cfg [2] = '{400, 160};
    int m_x[2], m_y[2], m_dir[2], m_anim[2], m_step[2], m_dead[2], m_inv[2];
    int m_cnt[2], m_period[2], m_pend[2], m_halt[2];
    int m_pc[2], m_plm[2], m_prm[2], m_pbm[2];

    task automatic m_reset(input int k);
        m_x[k] = 48; m_y[k] = 64; m_dir[k] = 0; m_anim[k] = 0; m_step[k] = 0;
        m_dead[k] = 0; m_inv[k] = 0; m_cnt[k] = 0; m_period[k] = 55;
        m_pend[k] = 0; m_halt[k] = 0;
    endtask

    // Summarise the mask as a whole: population, extreme columns, lowest row
    task automatic m_trigger(input int k);
        m_pc[k] = 0; m_plm[k] = 99; m_prm[k] = 0; m_pbm[k] = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 11; c++)
                if (invaders[r*11 + c]) begin
                    m_pc[k]++;
                    if (c < m_plm[k]) m_plm[k] = c;
                    if (c > m_prm[k]) m_prm[k] = c;
                    if (r > m_pbm[k]) m_pbm[k] = r;
                end
    endtask

    task automatic m_apply(input int k);
        int l, r;
        bit drop;
        if (m_pc[k] == 0) begin
            m_dead[k] = 1; m_halt[k] = 1;
        end else begin
            l = m_x[k] + m_plm[k] * 16;
            r = m_x[k] + (m_prm[k] + 1) * 16;
            drop = (m_dir[k] == 0) ? (r + 2 > rb_cfg[k]) : (l < 10);
            if (drop) begin
                m_y[k] += 8; m_dir[k] = 1 - m_dir[k];
            end else begin
                m_x[k] += (m_dir[k] == 0) ? 2 : -2;
            end
            m_step[k] = 1; m_anim[k] = 1 - m_anim[k];
`ifdef MARCH_SPEEDUP_EN
            m_period[k] = (m_pc[k] < 1) ? 1 : m_pc[k];
`else
            m_period[k] = 16;
`endif
            if (m_y[k] + (m_pbm[k] + 1) * 16 >= by_cfg[k]) begin
                m_inv[k] = 1; m_halt[k] = 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || restart) m_reset(k);
            else begin
                m_step[k] = 0;
                if (m_halt[k] != 0) begin
                end else if (!run) begin
                    m_pend[k] = 0; m_cnt[k] = 0;
                end else if (m_pend[k] > 0) begin
                    if (frame) m_cnt[k]++;
                    m_pend[k]--;
                    if (m_pend[k] == 0) m_apply(k);
                end else if (frame) begin
                    if (m_cnt[k] + 1 >= m_period[k]) begin
                        m_trigger(k); m_cnt[k] = 0; m_pend[k] = 12;
                    end else m_cnt[k]++;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit f, input bit rs);
        frame = f; restart = rs;
        @(posedge clk); @(negedge clk);
        frame = 1'b0; restart = 1'b0;
    endtask

    task automatic send_frames(input int n, output int steps0);
        steps0 = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0); steps0 += int'(o_step[0]);
            drive(1'b0, 1'b0); steps0 += int'(o_step[0]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        run = 1'b0; invaders = '1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_x[k] !== 10'd48 || o_y[k] !== 10'd64 || o_step[k] !== 1'b0 || o_anim[k] !== 1'b0
                || o_dead[k] !== 1'b0 || o_inv[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset[%0d]: got x=%0d y=%0d step=%b anim=%b dead=%b inv=%b expected 48 64 0 0 0 0",
                         k, o_x[k], o_y[k], o_step[k], o_anim[k], o_dead[k], o_inv[k]);
            end
        end
    endtask

    task automatic test_first_step();
        int s;
        run = 1'b1; invaders = '1;
        send_frames(54, s);
        n_checks++;
        if (s !== 0) begin n_errors++; $display("FAIL early_step: got %0d steps expected 0", s); end
        drive(1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            drive(1'b0, 1'b0);
            n_checks++;
            if (o_step[0] !== (c == 12)) begin
                n_errors++;
                $display("FAIL step_latency: cycle %0d got step=%b expected %b", c, o_step[0], c == 12);
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_x[k] !== 10'd50 || o_y[k] !== 10'd64 || o_anim[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL first_step[%0d]: got x=%0d y=%0d anim=%b expected 50 64 1", k, o_x[k], o_y[k], o_anim[k]);
            end
        end
    endtask

    task automatic test_wall();
        int n1 = 1;
        int cyc = 0;
        while (n1 < 3 && cyc < 3000) begin
            drive(cyc % 2 == 0, 1'b0);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_step[k] !== 1'(m_step[k]) || o_x[k] !== 10'(m_x[k]) || o_y[k] !== 10'(m_y[k])) begin
                    n_errors++;
                    $display("FAIL wall_model[%0d]: got step=%b x=%0d y=%0d expected %0d %0d %0d",
                             k, o_step[k], o_x[k], o_y[k], m_step[k], m_x[k], m_y[k]);
                end
            end
            if (o_step[1]) begin
                n1++;
                n_checks++;
                if ((n1 == 2 && (o_x[1] !== 10'd50 || o_y[1] !== 10'd72)) ||
                    (n1 == 3 && (o_x[1] !== 10'd48 || o_y[1] !== 10'd72))) begin
                    n_errors++;
                    $display("FAIL wall_step%0d: got x=%0d y=%0d expected %0d 72", n1, o_x[1], o_y[1], n1 == 2 ? 50 : 48);
                end
            end
        end
        n_checks++;
        if (n1 != 3) begin n_errors++; $display("FAIL wall_budget: got %0d steps expected 3", n1); end
    endtask

    task automatic test_invasion();
        int cyc = 0;
        logic [9:0] hx, hy;
        while (o_inv[1] !== 1'b1 && cyc < 12000) begin
            drive(cyc % 2 == 0, 1'b0);
            cyc++;
            n_checks++;
            if (o_inv[1] !== 1'(m_inv[1]) || o_y[1] !== 10'(m_y[1]) || o_x[1] !== 10'(m_x[1])) begin
                n_errors++;
                $display("FAIL invasion_model: got inv=%b x=%0d y=%0d expected %0d %0d %0d",
                         o_inv[1], o_x[1], o_y[1], m_inv[1], m_x[1], m_y[1]);
            end
        end
        n_checks++;
        if (o_inv[1] !== 1'b1 || o_x[1] !== 10'd8 || o_y[1] !== 10'd80) begin
            n_errors++;
            $display("FAIL invaded: got inv=%b x=%0d y=%0d expected 1 8 80", o_inv[1], o_x[1], o_y[1]);
        end
        hx = o_x[1]; hy = o_y[1];
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0);
            n_checks++;
            if (o_step[1] !== 1'b0 || o_x[1] !== hx || o_y[1] !== hy || o_inv[1] !== 1'b1) begin
                n_errors++;
                $display("FAIL halt_frozen: got step=%b x=%0d y=%0d inv=%b expected 0 %0d %0d 1",
                         o_step[1], o_x[1], o_y[1], o_inv[1], hx, hy);
            end
        end
    endtask

    task automatic test_all_dead();
        int s;
        invaders = '0;
        drive(1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_x[k] !== 10'd48 || o_y[k] !== 10'd64 || o_anim[k] !== 1'b0 || o_inv[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL restart[%0d]: got x=%0d y=%0d anim=%b inv=%b expected 48 64 0 0",
                         k, o_x[k], o_y[k], o_anim[k], o_inv[k]);
            end
        end
        send_frames(54, s);
        drive(1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            drive(1'b0, 1'b0);
            n_checks++;
            if (o_dead[0] !== (c >= 12) || o_step[0] !== 1'b0 || o_x[0] !== 10'd48) begin
                n_errors++;
                $display("FAIL all_dead: cycle %0d got dead=%b step=%b x=%0d expected %b 0 48",
                         c, o_dead[0], o_step[0], o_x[0], c >= 12);
            end
        end
        drive(1'b0, 1'b1);
        n_checks++;
        if (o_dead[0] !== 1'b0) begin n_errors++; $display("FAIL dead_clear: got %b expected 0", o_dead[0]); end
    endtask

    task automatic test_run_drop();
        int s;
        invaders = '1;
        drive(1'b0, 1'b1);
        send_frames(54, s);
        drive(1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b0);
        run = 1'b0; drive(1'b0, 1'b0); run = 1'b1;
        s = 0;
        repeat (20) begin drive(1'b0, 1'b0); s += int'(o_step[0]); end
        n_checks++;
        if (s != 0 || o_x[0] !== 10'd48 || o_y[0] !== 10'd64) begin
            n_errors++;
            $display("FAIL run_drop: got steps=%0d x=%0d y=%0d expected 0 48 64", s, o_x[0], o_y[0]);
        end
        send_frames(54, s);
        n_checks++;
        if (s != 0) begin n_errors++; $display("FAIL run_drop_count: got %0d steps expected 0", s); end
        drive(1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            drive(1'b0, 1'b0);
            n_checks++;
            if (o_step[0] !== (c == 12)) begin
                n_errors++;
                $display("FAIL run_drop_resume: cycle %0d got step=%b expected %b", c, o_step[0], c == 12);
            end
        end
    endtask

    task automatic test_rst_mid_scan();
        int s;
        int p = m_period[0];
        send_frames(p - 1, s);
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_x[k] !== 10'd48 || o_y[k] !== 10'd64 || o_step[k] !== 1'b0 || o_anim[k] !== 1'b0
                || o_dead[k] !== 1'b0 || o_inv[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_mid_scan[%0d]: got x=%0d y=%0d step=%b anim=%b dead=%b inv=%b expected 48 64 0 0 0 0",
                         k, o_x[k], o_y[k], o_step[k], o_anim[k], o_dead[k], o_inv[k]);
            end
        end
        send_frames(54, s);
        n_checks++;
        if (s != 0) begin n_errors++; $display("FAIL rst_period: got %0d steps in 54 frames expected 0", s); end
        drive(1'b1, 1'b0);
        repeat (12) drive(1'b0, 1'b0);
        n_checks++;
        if (o_step[0] !== 1'b1 || o_x[0] !== 10'd50) begin
            n_errors++;
            $display("FAIL rst_next_step: got step=%b x=%0d expected 1 50", o_step[0], o_x[0]);
        end
    endtask

    task automatic test_random();
        logic [63:0] t;
        int sel, c;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                sel = $urandom_range(0, 9);
                t = {$urandom(), $urandom()};
                if (sel == 0) invaders = '0;
                else if (sel <= 2) invaders = '1;
                else if (sel <= 5) begin
                    c = $urandom_range(0, 10);
                    invaders = '0;
                    for (int r = 0; r < 5; r++) if (t[r]) invaders[r*11 + c] = 1'b1;
                    invaders[$urandom_range(0, 4)*11 + c] = 1'b1;
                end else invaders = t[54:0];
            end
            run = ($urandom_range(0, 59) != 0);
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 249) == 0);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_x[k] !== 10'(m_x[k]) || o_y[k] !== 10'(m_y[k]) || o_step[k] !== 1'(m_step[k]) ||
                    o_anim[k] !== 1'(m_anim[k]) || o_dead[k] !== 1'(m_dead[k]) || o_inv[k] !== 1'(m_inv[k])) begin
                    n_errors++;
                    $display("FAIL random[%0d] cyc %0d: got x=%0d y=%0d step=%b anim=%b dead=%b inv=%b expected %0d %0d %0d %0d %0d %0d",
                             k, i, o_x[k], o_y[k], o_step[k], o_anim[k], o_dead[k], o_inv[k],
                             m_x[k], m_y[k], m_step[k], m_anim[k], m_dead[k], m_inv[k]);
                end
            end
        end
        run = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_step();
        test_wall();
        test_invasion();
        test_all_dead();
        test_run_drop();
        test_rst_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
